// File: rtl/pic_ack_pkg.sv
// Shared constants for the 8259A-style interrupt acknowledge sequencer:
// control-state encodings, the MCS-80 CALL opcode and a one-hot to index helper.
package pic_ack_pkg;

    typedef enum logic [2:0] {
        CTRL_IDLE = 3'b000,
        CTRL_ACK1 = 3'b001,
        CTRL_ACK2 = 3'b010,
        CTRL_ACK3 = 3'b011,
        CTRL_POLL = 3'b100
    } ctrl_state_t;

    localparam logic [7:0] CALL_OPCODE = 8'hCD;

    // One-hot (or multi-hot) to index; the lowest set bit wins.
    function automatic logic [2:0] bit2num(input logic [7:0] one_hot);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (one_hot[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pic_vector_formatter.sv
// Combinational byte former for the acknowledge and poll cycles: CALL opcode,
// low vector byte (8086 or MCS-80 interval 4/8), high vector byte, poll word.
module pic_vector_formatter
    import pic_ack_pkg::*;
#(
    parameter int         NUM_IR   = 8,
    parameter int         ID_W     = $clog2(NUM_IR),
    parameter logic [7:0] CALL_OP  = pic_ack_pkg::CALL_OPCODE
) (
    input  logic              mcs80_mode,
    input  logic              interval_8,
    input  logic [15:0]       vector_address,
    input  logic [ID_W-1:0]   id,
    input  logic              request_valid,
    input  ctrl_state_t       state,
    output logic [7:0]        data_byte
);

    logic [3:0] shift;
    logic [3:0] low_w;
    logic [7:0] id_ext;

    always_comb begin
        shift  = 4'd0;
        id_ext = 8'(id);
        if (mcs80_mode) shift = interval_8 ? 4'd3 : 4'd2;
        // Bits below the ID field (and the ID field itself) come from the index, not the base.
        low_w     = 4'(ID_W) + shift;
        data_byte = 8'h00;
        case (state)
            CTRL_ACK1: data_byte = CALL_OP;
            CTRL_ACK2: data_byte = ((vector_address[7:0] >> low_w) << low_w) | (id_ext << shift);
            CTRL_ACK3: data_byte = vector_address[15:8];
            CTRL_POLL: data_byte = request_valid ? (8'h80 | id_ext) : 8'h00;
            default:   data_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// INTA pulse sequencer: latches the winning IR on the first pulse, forms the
// vector bytes for 8086/MCS-80, drives the cascade bus and services poll reads.
module interrupt_ack_sequencer
    import pic_ack_pkg::*;
#(
    parameter int         NUM_IR      = 8,
    parameter int         ID_W        = $clog2(NUM_IR),
    parameter logic [7:0] CALL_OPCODE = pic_ack_pkg::CALL_OPCODE
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              interrupt_acknowledge_n,
    input  logic              u8086_or_mcs80_config,
    input  logic              call_address_interval_4_or_8_config,
    input  logic              single_or_cascade_config,
    input  logic              cascade_slave,
    input  logic [NUM_IR-1:0] cascade_device_config,
    input  logic [ID_W-1:0]   cascade_in,
    input  logic [NUM_IR-1:0] highest_request,
    input  logic [15:0]       interrupt_vector_address,
    input  logic              poll_command,
    input  logic              read,
    output logic [2:0]        control_state,
    output logic              freeze,
    output logic              isr_set_strobe,
    output logic [NUM_IR-1:0] isr_set_vector,
    output logic              end_of_ack_sequence,
    output logic              spurious,
    output logic [ID_W-1:0]   cascade_out,
    output logic              cascade_drive_en,
    output logic [7:0]        control_logic_data,
    output logic              out_control_logic_data
);

    ctrl_state_t       state_q, state_d;
    logic              prev_inta, prev_read;
    logic [NUM_IR-1:0] latch_q, latch_d;
    logic [ID_W-1:0]   id_q, id_d, req_id;
    logic              spurious_q, spurious_d;
    logic              strobe_d, eoa_d, oe_d;
    logic [7:0]        byte_d;
    logic [2:0]        req_idx;
    logic              fall, rise, read_rise, read_fall;
    logic              mcs80, is_slave, is_master, ack23_ok, in_ack;

    assign fall      = prev_inta & ~interrupt_acknowledge_n;
    assign rise      = ~prev_inta & interrupt_acknowledge_n;
    assign read_rise = ~prev_read & read;
    assign read_fall = prev_read & ~read;
    assign mcs80     = u8086_or_mcs80_config;
    assign is_slave  = ~single_or_cascade_config & cascade_slave;
    assign is_master = ~single_or_cascade_config & ~cascade_slave;

    // No request at the first pulse reports the lowest-priority index (IR7 / IR3).
    assign req_idx = bit2num(8'(highest_request));
    assign req_id  = (highest_request == '0) ? ID_W'(NUM_IR - 1) : req_idx[ID_W-1:0];

    always_comb begin
        state_d    = state_q;
        latch_d    = latch_q;
        id_d       = id_q;
        spurious_d = spurious_q;
        strobe_d   = 1'b0;
        eoa_d      = 1'b0;
        case (state_q)
            CTRL_IDLE: begin
                if (fall) begin
                    state_d    = CTRL_ACK1;
                    latch_d    = highest_request;
                    id_d       = req_id;
                    spurious_d = (highest_request == '0);
                    strobe_d   = (highest_request != '0);
                end else if (poll_command && read_rise) begin
                    state_d  = CTRL_POLL;
                    latch_d  = highest_request;
                    id_d     = req_id;
                    strobe_d = (highest_request != '0);
                end
            end
            CTRL_ACK1: if (fall) state_d = CTRL_ACK2;
            CTRL_ACK2: begin
                if (fall && mcs80) begin
                    state_d = CTRL_ACK3;
                end else if (rise && !mcs80) begin
                    state_d    = CTRL_IDLE;
                    eoa_d      = 1'b1;
                    spurious_d = 1'b0;
                end
            end
            CTRL_ACK3: begin
                if (rise) begin
                    state_d    = CTRL_IDLE;
                    eoa_d      = 1'b1;
                    spurious_d = 1'b0;
                end
            end
            CTRL_POLL: if (read_fall) state_d = CTRL_IDLE;
            default:   state_d = CTRL_IDLE;
        endcase
    end

    // A master stays off the bus in ACK2/ACK3 when the IR belongs to a slave.
    assign ack23_ok = single_or_cascade_config
                    | (is_slave & (cascade_in == cascade_device_config[ID_W-1:0]))
                    | (is_master & ~|(latch_d & cascade_device_config));

    // out_control_logic_data qualifies control_logic_data: the byte is valid on
    // every cycle the enable is high; the data-bus buffer cannot stall it.
    always_comb begin
        oe_d = 1'b0;
        case (state_d)
            CTRL_ACK1: oe_d = ~interrupt_acknowledge_n & mcs80 & ~is_slave;
            CTRL_ACK2,
            CTRL_ACK3: oe_d = ~interrupt_acknowledge_n & ack23_ok;
            CTRL_POLL: oe_d = read;
            default:   oe_d = 1'b0;
        endcase
    end

    pic_vector_formatter #(
        .NUM_IR  (NUM_IR),
        .ID_W    (ID_W),
        .CALL_OP (CALL_OPCODE)
    ) u_formatter (
        .mcs80_mode     (mcs80),
        .interval_8     (call_address_interval_4_or_8_config),
        .vector_address (interrupt_vector_address),
        .id             (id_d),
        .request_valid  (latch_d != '0),
        .state          (state_d),
        .data_byte      (byte_d)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q                <= CTRL_IDLE;
            prev_inta              <= 1'b1;
            prev_read              <= 1'b0;
            latch_q                <= '0;
            id_q                   <= '0;
            spurious_q             <= 1'b0;
            isr_set_strobe         <= 1'b0;
            isr_set_vector         <= '0;
            end_of_ack_sequence    <= 1'b0;
            control_logic_data     <= 8'h00;
            out_control_logic_data <= 1'b0;
        end else begin
            state_q                <= state_d;
            prev_inta              <= interrupt_acknowledge_n;
            prev_read              <= read;
            latch_q                <= latch_d;
            id_q                   <= id_d;
            spurious_q             <= spurious_d;
            isr_set_strobe         <= strobe_d;
            isr_set_vector         <= strobe_d ? highest_request : '0;
            end_of_ack_sequence    <= eoa_d;
            control_logic_data     <= oe_d ? byte_d : 8'h00;
            out_control_logic_data <= oe_d;
        end
    end

    assign in_ack           = (state_q == CTRL_ACK1) || (state_q == CTRL_ACK2) || (state_q == CTRL_ACK3);
    assign control_state    = state_q;
    assign freeze           = in_ack;
    assign spurious         = spurious_q;
    assign cascade_drive_en = is_master & in_ack & |(latch_q & cascade_device_config);
    assign cascade_out      = cascade_drive_en ? id_q : '0;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer (8-IR and 4-IR instances):
// expected bytes/ISR vectors are queued as stimulus is issued and a monitor pops them.
module tb_interrupt_ack_sequencer;

    logic        clock;
    logic        reset_n;
    logic        inta_n;
    logic        mode_mcs80;
    logic        interval_8;
    logic        single;
    logic        slave;
    logic [7:0]  cfg;
    logic [2:0]  cin;
    logic [7:0]  hr;
    logic [15:0] addr;
    logic        poll;
    logic        rd;

    logic [2:0] control_state;
    logic       freeze, isr_set_strobe, end_of_ack_sequence, spurious;
    logic [7:0] isr_set_vector;
    logic [2:0] cascade_out;
    logic       cascade_drive_en;
    logic [7:0] control_logic_data;
    logic       out_control_logic_data;

    logic [2:0] d4_state;
    logic       d4_freeze, d4_strobe, d4_eoa, d4_spurious;
    logic [3:0] d4_vec;
    logic [1:0] d4_cout;
    logic       d4_cdrv;
    logic [7:0] d4_data;
    logic       d4_oe;

    int total = 0;
    int bad   = 0;
    logic       mon4_en = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_vec_q[$];
    logic [7:0] exp4_q[$];

    interrupt_ack_sequencer #(.NUM_IR(8)) dut (
        .clock                               (clock),
        .reset_n                             (reset_n),
        .interrupt_acknowledge_n             (inta_n),
        .u8086_or_mcs80_config               (mode_mcs80),
        .call_address_interval_4_or_8_config (interval_8),
        .single_or_cascade_config            (single),
        .cascade_slave                       (slave),
        .cascade_device_config               (cfg),
        .cascade_in                          (cin),
        .highest_request                     (hr),
        .interrupt_vector_address            (addr),
        .poll_command                        (poll),
        .read                                (rd),
        .control_state                       (control_state),
        .freeze                              (freeze),
        .isr_set_strobe                      (isr_set_strobe),
        .isr_set_vector                      (isr_set_vector),
        .end_of_ack_sequence                 (end_of_ack_sequence),
        .spurious                            (spurious),
        .cascade_out                         (cascade_out),
        .cascade_drive_en                    (cascade_drive_en),
        .control_logic_data                  (control_logic_data),
        .out_control_logic_data              (out_control_logic_data)
    );

    interrupt_ack_sequencer #(.NUM_IR(4)) dut4 (
        .clock                               (clock),
        .reset_n                             (reset_n),
        .interrupt_acknowledge_n             (inta_n),
        .u8086_or_mcs80_config               (mode_mcs80),
        .call_address_interval_4_or_8_config (interval_8),
        .single_or_cascade_config            (single),
        .cascade_slave                       (slave),
        .cascade_device_config               (cfg[3:0]),
        .cascade_in                          (cin[1:0]),
        .highest_request                     (hr[3:0]),
        .interrupt_vector_address            (addr),
        .poll_command                        (poll),
        .read                                (rd),
        .control_state                       (d4_state),
        .freeze                              (d4_freeze),
        .isr_set_strobe                      (d4_strobe),
        .isr_set_vector                      (d4_vec),
        .end_of_ack_sequence                 (d4_eoa),
        .spurious                            (d4_spurious),
        .cascade_out                         (d4_cout),
        .cascade_drive_en                    (d4_cdrv),
        .control_logic_data                  (d4_data),
        .out_control_logic_data              (d4_oe)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- driver / check tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fall_edge();
        inta_n = 1'b0;
        tick(1);
    endtask

    task automatic rise_edge();
        tick(2);
        inta_n = 1'b1;
        tick(1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic monitor();
        logic prev_oe, prev_oe4;
        prev_oe  = 1'b0;
        prev_oe4 = 1'b0;
        forever begin
            @(negedge clock);
            if (out_control_logic_data && !prev_oe) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL data_unexpected: got %02h expected no drive", control_logic_data);
                end else begin
                    check("data_byte", 16'(control_logic_data), 16'(exp_q.pop_front()));
                end
            end
            prev_oe = out_control_logic_data;
            if (isr_set_strobe) begin
                if (exp_vec_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL strobe_unexpected: got vector %02h expected no strobe", isr_set_vector);
                end else begin
                    check("isr_set_vector", 16'(isr_set_vector), 16'(exp_vec_q.pop_front()));
                end
            end
            if (mon4_en && d4_oe && !prev_oe4) begin
                if (exp4_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL d4_data_unexpected: got %02h expected no drive", d4_data);
                end else begin
                    check("d4_data_byte", 16'(d4_data), 16'(exp4_q.pop_front()));
                end
            end
            prev_oe4 = d4_oe;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0; inta_n = 1'b1; mode_mcs80 = 1'b0; interval_8 = 1'b0;
        single = 1'b1; slave = 1'b0; cfg = 8'h00; cin = 3'd0; hr = 8'h00;
        addr = 16'h0000; poll = 1'b0; rd = 1'b0;
        fork
            monitor();
        join_none
        tick(3);
        check("rst_state", 16'(control_state), 16'h0);
        check("rst_data", 16'(control_logic_data), 16'h00);
        check("rst_oe", 16'(out_control_logic_data), 16'h0);
        check("rst_freeze", 16'(freeze), 16'h0);
        check("rst_strobe", 16'(isr_set_strobe), 16'h0);
        check("rst_vector", 16'(isr_set_vector), 16'h0);
        check("rst_eoa", 16'(end_of_ack_sequence), 16'h0);
        check("rst_cdrv", 16'(cascade_drive_en), 16'h0);
        reset_n = 1'b1;
        tick(2);

        // 8086 single, IR3 at base 0x40 -> ACK2 byte 0x43
        addr = 16'h0040; hr = 8'h08;
        exp_vec_q.push_back(8'h08); exp_q.push_back(8'h43);
        fall_edge();
        check("t1_ack1_state", 16'(control_state), 16'h1);
        check("t1_freeze", 16'(freeze), 16'h1);
        check("t1_ack1_no_drive", 16'(out_control_logic_data), 16'h0);
        hr = 8'h01;  // must not disturb the latched IR3
        rise_edge();
        check("t1_rise1_ignored", 16'(control_state), 16'h1);
        check("t1_no_early_eoa", 16'(end_of_ack_sequence), 16'h0);
        tick(1); fall_edge();
        check("t1_ack2_state", 16'(control_state), 16'h2);
        rise_edge();
        check("t1_eoa", 16'(end_of_ack_sequence), 16'h1);
        check("t1_idle", 16'(control_state), 16'h0);
        check("t1_unfreeze", 16'(freeze), 16'h0);
        tick(1);
        check("t1_eoa_one_cycle", 16'(end_of_ack_sequence), 16'h0);

        // MCS-80 interval 4, IR5, base 0x12E0 -> CD, F4, 12
        mode_mcs80 = 1'b1; addr = 16'h12E0; hr = 8'h20;
        exp_vec_q.push_back(8'h20);
        exp_q.push_back(8'hCD); exp_q.push_back(8'hF4); exp_q.push_back(8'h12);
        fall_edge(); rise_edge(); tick(1);
        fall_edge();
        rise_edge();
        check("t2_ack2_rise_ignored", 16'(control_state), 16'h2);
        check("t2_no_eoa_ack2", 16'(end_of_ack_sequence), 16'h0);
        tick(1); fall_edge();
        check("t2_ack3_state", 16'(control_state), 16'h3);
        rise_edge();
        check("t2_eoa", 16'(end_of_ack_sequence), 16'h1);
        tick(2);

        // Cascade master, slave on IR2: only the CALL byte from the master
        single = 1'b0; slave = 1'b0; cfg = 8'h04; hr = 8'h04;
        exp_vec_q.push_back(8'h04); exp_q.push_back(8'hCD);
        fall_edge();
        check("t3_cout_ack1", 16'(cascade_out), 16'h2);
        check("t3_cdrv_ack1", 16'(cascade_drive_en), 16'h1);
        rise_edge(); tick(1); fall_edge(); rise_edge(); tick(1);
        fall_edge();
        check("t3_cout_ack3", 16'(cascade_out), 16'h2);
        check("t3_cdrv_ack3", 16'(cascade_drive_en), 16'h1);
        rise_edge();
        check("t3_cdrv_end", 16'(cascade_drive_en), 16'h0);
        check("t3_cout_end", 16'(cascade_out), 16'h0);
        tick(2);

        // Slave ID 2, 8086: addressed (cascade_in=2) drives ACK2, IR0 -> 0x40
        mode_mcs80 = 1'b0; addr = 16'h0040; slave = 1'b1; cfg = 8'h02; cin = 3'd2; hr = 8'h01;
        exp_vec_q.push_back(8'h01); exp_q.push_back(8'h40);
        fall_edge();
        check("t3s_cdrv", 16'(cascade_drive_en), 16'h0);
        rise_edge(); tick(1); fall_edge(); rise_edge(); tick(2);
        // Slave not addressed (cascade_in=3): strobe but no data
        cin = 3'd3; hr = 8'h02;
        exp_vec_q.push_back(8'h02);
        fall_edge(); rise_edge(); tick(1); fall_edge(); rise_edge();
        check("t3n_eoa", 16'(end_of_ack_sequence), 16'h1);
        tick(2);

        // Spurious: no request -> no strobe, index 7 -> 0x47
        single = 1'b1; slave = 1'b0; cfg = 8'h00; cin = 3'd0; hr = 8'h00;
        exp_q.push_back(8'h47);
        fall_edge();
        check("t4_spurious", 16'(spurious), 16'h1);
        check("t4_no_strobe", 16'(isr_set_strobe), 16'h0);
        rise_edge(); tick(1); fall_edge(); rise_edge();
        check("t4_spurious_clear", 16'(spurious), 16'h0);
        tick(2);

        // 4-IR instance: 8086, IR3 at base 0x88 -> 0x8B (8-IR instance also 0x8B)
        mon4_en = 1'b1; addr = 16'h0088; hr = 8'h08;
        exp_vec_q.push_back(8'h08); exp_q.push_back(8'h8B); exp4_q.push_back(8'h8B);
        fall_edge(); rise_edge(); tick(1); fall_edge(); rise_edge();
        tick(2);
        mon4_en = 1'b0;

        // Poll read with IR5 pending -> 0x85 and strobe
        poll = 1'b1; hr = 8'h20;
        exp_vec_q.push_back(8'h20); exp_q.push_back(8'h85);
        rd = 1'b1; tick(1);
        check("t6_poll_state", 16'(control_state), 16'h4);
        tick(2);
        rd = 1'b0; tick(1);
        check("t6_poll_exit", 16'(control_state), 16'h0);
        check("t6_poll_oe_off", 16'(out_control_logic_data), 16'h0);
        tick(2);

        // INTA fall together with a poll read: acknowledge wins
        addr = 16'h0040; hr = 8'h02;
        exp_vec_q.push_back(8'h02); exp_q.push_back(8'h41);
        rd = 1'b1; inta_n = 1'b0; tick(1);
        check("t6_inta_wins", 16'(control_state), 16'h1);
        rise_edge(); rd = 1'b0; poll = 1'b0; tick(1); fall_edge(); rise_edge();
        tick(2);

        // Reset during ACK2: abort, no end pulse
        hr = 8'h08;
        exp_vec_q.push_back(8'h08); exp_q.push_back(8'h43);
        fall_edge(); rise_edge(); tick(1); fall_edge(); tick(1);
        reset_n = 1'b0; inta_n = 1'b1; tick(1);
        check("t7_rst_state", 16'(control_state), 16'h0);
        check("t7_rst_freeze", 16'(freeze), 16'h0);
        check("t7_rst_oe", 16'(out_control_logic_data), 16'h0);
        check("t7_rst_data", 16'(control_logic_data), 16'h00);
        check("t7_rst_eoa", 16'(end_of_ack_sequence), 16'h0);
        reset_n = 1'b1; tick(1);
        check("t7_no_eoa_after", 16'(end_of_ack_sequence), 16'h0);
        check("t7_still_idle", 16'(control_state), 16'h0);
        tick(3);

        check("exp_q_drained", 16'(exp_q.size()), 16'h0);
        check("exp_vec_q_drained", 16'(exp_vec_q.size()), 16'h0);
        check("exp4_q_drained", 16'(exp4_q.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interrupt_ack_sequencer.md
Name: interrupt_ack_sequencer

Overview:
- Clocked successor to the combinational cascade/acknowledge logic of the 8259A controller.
- Counts INTA pulses with a state machine and latches the winning IR at the first pulse.
- Formats the vector bytes for 8086 (2-pulse) and MCS-80 (3-pulse) modes, drives the cascade bus as master or slave, and services poll reads.
- Sits between the priority resolver/ISR and the data-bus buffer; parametrised in IR channel count.

Parameters:
- NUM_IR, 8, number of IR inputs per device; legal values 4 or 8.
- ID_W, $clog2(NUM_IR), width of the IR index and cascade ID (derived; do not override).
- CALL_OPCODE, 8'hCD, first-pulse byte in MCS-80 mode.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- interrupt_acknowledge_n  in  1  INTA pin, already synchronised to clock
- u8086_or_mcs80_config  in  1  0 = 8086, 1 = MCS-80
- call_address_interval_4_or_8_config  in  1  MCS-80 only: 0 = interval 4, 1 = interval 8
- single_or_cascade_config  in  1  1 = single device
- cascade_slave  in  1  1 = this device is a slave
- cascade_device_config  in  NUM_IR  master: IRs with a slave attached; slave: [ID_W-1:0] = own ID
- cascade_in  in  ID_W  cascade bus value (slave)
- highest_request  in  NUM_IR  one-hot winning IR from the priority resolver (zero = none)
- interrupt_vector_address  in  16  vector base (8086 uses [7:ID_W]; MCS-80 uses all 16 bits)
- poll_command  in  1  OCW3 poll armed
- read  in  1  RD strobe
- control_state  out  3  IDLE=000, ACK1=001, ACK2=010, ACK3=011, POLL=100
- freeze  out  1  high from the ACK1 edge until sequence end; request latch is held
- isr_set_strobe  out  1  one-cycle pulse to set the ISR bit
- isr_set_vector  out  NUM_IR  one-hot IR to set; valid with isr_set_strobe
- end_of_ack_sequence  out  1  one-cycle pulse at the final INTA rising edge (AEOI hook)
- spurious  out  1  sticky flag for the current sequence; the latched request was zero
- cascade_out  out  ID_W  cascade ID driven by the master
- cascade_drive_en  out  1  master drives the cascade bus
- control_logic_data  out  8  data-bus byte
- out_control_logic_data  out  1  data-bus drive enable

Behaviour:
- Reset (reset_n=0 at a clock edge): state IDLE, prev_inta=1, latch=0.
  - All outputs go to 0, including control_logic_data=8'h00 (no z internally).
- Edge detection:
  - Registered prev_inta.
  - fall = prev & ~pin; rise = ~prev & pin.
  - State transitions occur on the clock edge that sees fall or rise.
- IDLE + fall → ACK1:
  - latch <= highest_request, freeze=1, control_state=ACK1.
  - If highest_request≠0: isr_set_strobe for exactly 1 cycle with isr_set_vector=highest_request.
  - If highest_request=0: latch index forced to NUM_IR-1, spurious=1, no strobe.
- ACK1 + fall → ACK2; ACK2 + fall → ACK3 (MCS-80 only). A fall in 8086 ACK2 is ignored.
- Final rise:
  - Final state is ACK2 (8086) or ACK3 (MCS-80).
  - Pulse end_of_ack_sequence for 1 cycle, clear freeze and spurious, return to IDLE.
  - Rises in non-final states are ignored.
- Data drive:
  - out_control_logic_data is high only while INTA is low in an enabled state.
  - Output is registered: 1-cycle latency from fall, deasserts the cycle after rise.
- ack23_ok =
  - single_or_cascade_config, OR
  - slave with cascade_in == own ID, OR
  - master whose latched IR is not in cascade_device_config.
- ACK1: MCS-80 master drives CALL_OPCODE, even for a cascaded IR. 8086 mode drives nothing. A slave never drives in ACK1.
- ACK2 with ack23_ok, id = index of latch (bit2num):
  - 8086: {interrupt_vector_address[7:ID_W], id}.
  - MCS-80, interval 4: {addr[7:ID_W+2], id, 2'b00}.
  - MCS-80, interval 8: {addr[7:ID_W+3], id, 3'b000}.
  - For NUM_IR=8 with interval 8, addr[7:6] is used.
- ACK3 with ack23_ok: interrupt_vector_address[15:8].
- Cascade master (not single, not slave), while latched IR ∈ cascade_device_config, from ACK1 through end:
  - cascade_drive_en=1, cascade_out=id.
  - Otherwise cascade_out=0 and cascade_drive_en=0.
- Slave: cascade_in is compared live during ACK2/ACK3. cascade_drive_en is always 0.
- Poll, IDLE + poll_command + read rising:
  - → POLL; latch request.
  - isr_set_strobe if nonzero.
  - Drive {1'b1, 0…, id} (8'h00 if none) while read=1.
  - Return to IDLE when read falls.
- Simultaneous events:
  - fall in the same cycle as a poll read start: INTA wins and the poll is dropped.
  - highest_request changes while freeze=1: ignored.
- Config inputs are sampled live. Changing them mid-sequence is undefined except via reset.
- reset_n=0 mid-sequence: abort to IDLE next edge, with no end_of_ack_sequence pulse.

Decomposition:
- Package pic_ack_pkg:
  - control-state localparams (IDLE/ACK1/ACK2/ACK3/POLL)
  - CALL_OPCODE
  - function bit2num (one-hot → index, priority to LSB)
- Sub-module pic_vector_formatter: combinational; (mode, interval, addr, id, state) → byte.
- The state machine stays in the top module.

Test Plan:
- 8086 single, addr=16'h0040, highest_request=8'h08:
  - two INTA pulses → ACK1 no drive, strobe with isr_set_vector=8'h08.
  - ACK2 byte 8'h43; end_of_ack_sequence at the 2nd rise.
- MCS-80 interval 4, addr=16'h12E0, IR5:
  - bytes CD, E0|(5<<2)=F4, 12 on pulses 1–3; one end pulse.
- Master cascade, cascade_device_config=8'h04, IR2:
  - cascade_out=3'd2 and drive_en from ACK1 through end.
  - no ACK2/ACK3 data from the master. Slave with ID 2 and cascade_in=2 drives ACK2.
- Spurious: highest_request=0 at the 1st fall → no strobe, spurious=1, 8086 ACK2 id=7.
- NUM_IR=4, 8086, addr=16'h0088, IR3 → ACK2 byte 8'h8B.
- Poll read with request 8'h20 → byte 8'h85 and strobe.
  - Assert reset_n=0 during ACK2 → IDLE next cycle, all outputs 0.
